drum_mul_arbiter: RTL and testbench

//  Shares one combinational DRUM approximate signed multiplier (drum, K/N/M) between
//  NUM_REQ requesters. Arbitration is round-robin with valid/ready handshakes.

---
 rtl/drum_pkg.sv | 15 +
 rtl/drum.sv | 54 +++++
 rtl/drum_mul_arbiter.sv | 104 ++++++++++
 tb/tb_drum_mul_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared types and default sizing for the DRUM multiplier arbiter.
package drum_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NUM_REQ_DFLT = 4;
    localparam int K_DFLT       = 6;
    localparam int N_DFLT       = 8;
    localparam int M_DFLT       = 8;
    localparam int ID_W         = $clog2(NUM_REQ_DFLT);
    localparam int R_W          = N_DFLT + M_DFLT;
endpackage

// File: rtl/drum.sv
// DRUM approximate signed multiplier: k-bit dynamic segments, ones-complement sign.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module drum #(
    parameter int k = 6,
    parameter int n = 8,
    parameter int m = 8
) (
    input  logic [n-1:0]   a,
    input  logic [m-1:0]   b,
    output logic [n+m-1:0] r
);
    logic [n-1:0]   abs_a;
    logic [m-1:0]   abs_b;
    logic [k-1:0]   seg_a;
    logic [k-1:0]   seg_b;
    logic [n+m-1:0] prod;
    int             lead_a;
    int             lead_b;
    int             sh_a;
    int             sh_b;

    always_comb begin
        abs_a  = a[n-1] ? ~a : a;
        abs_b  = b[m-1] ? ~b : b;
        lead_a = 0;
        lead_b = 0;
        for (int i = 0; i < n; i++) if (abs_a[i]) lead_a = i;
        for (int i = 0; i < m; i++) if (abs_b[i]) lead_b = i;

        // Small operands pass exactly; larger ones keep k bits from the leading one
        // with the LSB forced high to centre the truncation error.
        if (lead_a < k) begin
            sh_a  = 0;
            seg_a = abs_a[k-1:0];
        end else begin
            sh_a     = lead_a - k + 1;
            seg_a    = abs_a[sh_a +: k];
            seg_a[0] = 1'b1;
        end
        if (lead_b < k) begin
            sh_b  = 0;
            seg_b = abs_b[k-1:0];
        end else begin
            sh_b     = lead_b - k + 1;
            seg_b    = abs_b[sh_b +: k];
            seg_b[0] = 1'b1;
        end

        prod = (n+m)'(seg_a) * (n+m)'(seg_b);
        prod = prod << (sh_a + sh_b);
        r    = (a[n-1] ^ b[m-1]) ? ~prod : prod;
    end
endmodule

// File: rtl/drum_mul_arbiter.sv
// Round-robin share of one DRUM multiplier across NUM_REQ valid/ready requesters.
// Latency: response valid 2 edges after request acceptance; one op per 3 cycles.
// Backpressure: response held until rsp_ready; no new grant until it is taken.
module drum_mul_arbiter
    import drum_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DFLT,
    parameter int K       = K_DFLT,
    parameter int N       = N_DFLT,
    parameter int M       = M_DFLT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*N-1:0]       req_a,
    input  logic [NUM_REQ*M-1:0]       req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [N+M-1:0]             rsp_r,
    output logic [15:0]                ops_done
);
    localparam int IDW = $clog2(NUM_REQ);

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] grant_id;
    logic           grant_vld;
    logic           accept;
    logic [N-1:0]   a_q;
    logic [M-1:0]   b_q;
    logic [N+M-1:0] prod;
    int             idx;

    drum #(.k(K), .n(N), .m(M)) u_drum (
        .a (a_q),
        .b (b_q),
        .r (prod)
    );

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
        // rst_n gates the grant so no requester sees ready while reset is held.
        req_ready = '0;
        if (state_q == IDLE && grant_vld && rst_n) req_ready[grant_id] = 1'b1;
        accept = |(req_valid & req_ready);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_r     <= '0;
            ops_done  <= '0;
        end else begin
            if (accept) begin
                a_q    <= req_a[grant_id*N +: N];
                b_q    <= req_b[grant_id*M +: M];
                id_q   <= grant_id;
                rr_ptr <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            end
            if (state_q == CALC) begin
                rsp_r     <= prod;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
            if (state_q == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                ops_done  <= ops_done + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_drum_mul_arbiter.sv
// Directed bench for drum_mul_arbiter: reset, latency, DRUM values, round-robin, backpressure.
module tb_drum_mul_arbiter;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_r;
    logic [15:0] ops_done;

    int          n_chk;
    int          n_fail;
    logic [15:0] exp_ops;
    logic [15:0] hold_r;

    drum_mul_arbiter #(.NUM_REQ(4), .K(6), .N(8), .M(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input int idx, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_r);
        req_valid[idx]      = 1'b1;
        req_a[idx*8 +: 8]   = a;
        req_b[idx*8 +: 8]   = b;
        rsp_ready           = 1'b1;
        #1 chk("op_ready", {28'd0, req_ready}, 32'd1 << idx);
        tick();
        req_valid[idx] = 1'b0;
        chk("op_calc_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("op_rsp_id", {30'd0, rsp_id}, idx);
        chk("op_rsp_r", {16'd0, rsp_r}, {16'd0, exp_r});
        tick();
        rsp_ready = 1'b0;
        exp_ops   = exp_ops + 16'd1;
        chk("op_rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("op_ops_done", {16'd0, ops_done}, {16'd0, exp_ops});
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_ops   = 16'd0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_ops_done", {16'd0, ops_done}, 32'd0);
        chk("rst_rsp_r", {16'd0, rsp_r}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        req_valid = 4'b1111;
        #1 chk("rst_ready", {28'd0, req_ready}, 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        op(1, 8'd3, 8'd5, 16'h000F);
        op(0, 8'd100, 8'd3, 16'h0132);
        op(2, 8'hFD, 8'd5, 16'hFFF5);

        // Asynchronous reset in the middle of a held response
        req_valid[3]  = 1'b1;
        req_a[24 +: 8] = 8'd1;
        req_b[24 +: 8] = 8'd1;
        rsp_ready     = 1'b0;
        #1 chk("mid_ready", {28'd0, req_ready}, 32'b1000);
        tick();
        req_valid = '0;
        tick();
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_ops", {16'd0, ops_done}, 32'd0);
        req_valid = 4'b1111;
        #1 chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
        exp_ops = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(i + 1);
            req_b[i*8 +: 8] = 8'd2;
        end
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_ready", {28'd0, req_ready}, 32'd1 << (k % 4));
            tick();
            chk("rr_calc", {31'd0, rsp_valid}, 32'd0);
            tick();
            chk("rr_id", {30'd0, rsp_id}, k % 4);
            chk("rr_r", {16'd0, rsp_r}, 2 * ((k % 4) + 1));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            exp_ops   = exp_ops + 16'd1;
            chk("rr_ops", {16'd0, ops_done}, {16'd0, exp_ops});
        end
        req_valid = 4'b0001;
        #1 chk("rr_only0_ready", {28'd0, req_ready}, 32'b0001);
        tick();
        req_valid = '0;
        tick();
        chk("rr_only0_id", {30'd0, rsp_id}, 32'd0);
        chk("rr_only0_r", {16'd0, rsp_r}, 32'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops   = exp_ops + 16'd1;
        chk("rr_only0_ops", {16'd0, ops_done}, {16'd0, exp_ops});

        // Backpressure: response must stay frozen while others keep requesting
        req_valid      = 4'b0010;
        req_a[8 +: 8]  = 8'h9C;
        req_b[8 +: 8]  = 8'd7;
        #1 chk("bp_ready", {28'd0, req_ready}, 32'b0010);
        tick();
        req_valid = 4'b0101;
        tick();
        hold_r = 16'hFD51;
        chk("bp_r", {16'd0, rsp_r}, {16'd0, hold_r});
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_r", {16'd0, rsp_r}, {16'd0, hold_r});
            chk("bp_hold_id", {30'd0, rsp_id}, 32'd1);
            chk("bp_hold_ready", {28'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        exp_ops   = exp_ops + 16'd1;
        chk("bp_ops", {16'd0, ops_done}, {16'd0, exp_ops});
        chk("bp_drop", {31'd0, rsp_valid}, 32'd0);

        // Counter wrap
        force dut.ops_done = 16'hFFFF;
        #1 release dut.ops_done;
        exp_ops = 16'hFFFF;
        op(3, 8'd5, 8'hFE, 16'hFFFA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
